// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the push-button pulse generator: FSM state codes
// and default timing for a 100 MHz board clock.
package key_pulse_gen_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_CHK = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CHK   = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;
  localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; q lags d by two edges.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Debounces a raw push-button and emits one-cycle increment pulses, with an
// optional auto-repeat cadence while the button is held.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // state is kept as a plain named signal so checkers can bind to it
  logic [1:0]       state;
  logic             s2;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_last;
  logic             first;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (s2)
  );

  assign rep_last = first ? DELAY_LAST : PERIOD_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      deb_cnt <= '0;
      rep_cnt <= '0;
      first   <= 1'b1;
      pulse   <= 1'b0;
      level   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state   <= PRESS_CHK;
            deb_cnt <= CNT_W'(1);
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= HELD;
            pulse   <= 1'b1;
            level   <= 1'b1;
            deb_cnt <= '0;
            rep_cnt <= '0;
            first   <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s2) begin
            state   <= REL_CHK;
            deb_cnt <= CNT_W'(1);
          end else if (repeat_en) begin
            if (rep_cnt == rep_last) begin
              pulse   <= 1'b1;
              rep_cnt <= '0;
              first   <= 1'b0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end else begin
            // disabling repeat re-arms the long initial delay
            rep_cnt <= '0;
            first   <= 1'b1;
          end
        end
        REL_CHK: begin
          // a release glitch returns to HELD with the repeat timer untouched
          if (s2) begin
            state   <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            level   <= 1'b0;
            deb_cnt <= '0;
            rep_cnt <= '0;
            first   <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen: directed scenarios plus randomized
// button traffic compared against a run-length reference model.
module tb_key_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic repeat_en = 1'b0;
  logic pulse;
  logic level;

  int checks = 0;
  int failures = 0;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .pulse     (pulse),
    .level     (level)
  );

  always #5 clk = ~clk;

  // reference model: synchronizer delay line, debounced level, run length of
  // samples disagreeing with the level, and a held-time repeat timer
  logic     hist[$] = '{1'b0, 1'b0};
  logic     m_level = 1'b0;
  int       m_run = 0;
  int       m_rep = 0;
  logic     m_first = 1'b1;
  logic     m_pulse = 1'b0;
  logic [3:0] m_cnt = 4'd0;
  logic [3:0] cnt4 = 4'd0;
  int       dut_pulses = 0;
  logic [3:0] exp_q[$];

  task automatic model_update(input logic b, input logic r, input logic en);
    logic x;
    m_pulse = 1'b0;
    if (!r) begin
      hist = '{1'b0, 1'b0};
      m_level = 1'b0;
      m_run = 0;
      m_rep = 0;
      m_first = 1'b1;
      return;
    end
    hist.push_back(b);
    x = hist[hist.size() - 3];
    if (hist.size() > 3) void'(hist.pop_front());
    if (!m_level) begin
      m_run = x ? m_run + 1 : 0;
      if (m_run == D) begin
        m_level = 1'b1;
        m_pulse = 1'b1;
        m_run = 0;
        m_rep = 0;
        m_first = 1'b1;
      end
    end else if (!x) begin
      m_run++;
      if (m_run == D) begin
        m_level = 1'b0;
        m_run = 0;
      end
    end else if (m_run != 0) begin
      m_run = 0;
    end else if (en) begin
      m_rep++;
      if (m_rep == (m_first ? RD : RP)) begin
        m_pulse = 1'b1;
        m_rep = 0;
        m_first = 1'b0;
      end
    end else begin
      m_rep = 0;
      m_first = 1'b1;
    end
  endtask

  task automatic tick(input logic b, input logic r);
    btn_in = b;
    rst_n = r;
    @(posedge clk);
    model_update(b, r, repeat_en);
    #1;
    if (m_pulse) begin
      m_cnt = m_cnt + 4'd1;
      exp_q.push_back(m_cnt);
    end
    if (pulse === 1'b1) begin
      cnt4 = cnt4 + 4'd1;
      dut_pulses++;
    end
  endtask

  task automatic start_test(input logic en);
    repeat_en = en;
    tick(1'b0, 1'b0);
    cnt4 = 4'd0;
    m_cnt = 4'd0;
    dut_pulses = 0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    btn_in = 1'b1;
    tick(1'b1, 1'b0);
    checks++;
    if (pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulse got=%b want=0", pulse);
    end
    checks++;
    if (level !== 1'b0) begin
      failures++;
      $display("FAIL reset_level got=%b want=0", level);
    end
  endtask

  task automatic test_clean_press;
    start_test(1'b0);
    for (int e = 1; e <= 30; e++) begin
      tick(e >= 10, 1'b1);
      checks++;
      if (pulse !== (e == 15) || pulse !== m_pulse) begin
        failures++;
        $display("FAIL clean_press_pulse edge=%0d got=%b want=%b", e, pulse, m_pulse);
      end
      checks++;
      if (level !== (e >= 15) || level !== m_level) begin
        failures++;
        $display("FAIL clean_press_level edge=%0d got=%b want=%b", e, level, m_level);
      end
    end
  endtask

  task automatic test_bounce;
    start_test(1'b0);
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 3; c++) begin
        tick(c < 2, 1'b1);
        checks++;
        if (pulse !== 1'b0 || level !== 1'b0 || m_level !== 1'b0) begin
          failures++;
          $display("FAIL bounce pulse=%b level=%b want pulse=0 level=0", pulse, level);
        end
      end
    end
    repeat (6) tick(1'b0, 1'b1);
    checks++;
    if (dut.state !== 2'd0) begin
      failures++;
      $display("FAIL bounce_idle state=%0d want=0", dut.state);
    end
  endtask

  task automatic test_auto_repeat;
    start_test(1'b1);
    for (int e = 1; e <= 50; e++) begin
      tick(e >= 10, 1'b1);
      checks++;
      if (pulse !== m_pulse || pulse !== (e == 15 || (e >= 23 && (e - 23) % 4 == 0))) begin
        failures++;
        $display("FAIL auto_repeat_pulse edge=%0d got=%b want=%b", e, pulse, m_pulse);
      end
      if (pulse === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL auto_repeat_count got=%0d want=no pulse", cnt4);
        end else if (cnt4 !== exp_q.pop_front()) begin
          failures++;
          $display("FAIL auto_repeat_count got=%0d want=%0d", cnt4, m_cnt);
        end
      end
      if (e == 36) begin
        checks++;
        if (cnt4 !== 4'd5) begin
          failures++;
          $display("FAIL auto_repeat_edge36 got=%0d want=5", cnt4);
        end
      end
    end
  endtask

  task automatic test_release_glitch;
    start_test(1'b1);
    for (int e = 1; e <= 45; e++) begin
      tick(!(e < 2 || e == 20 || e == 21), 1'b1);
      checks++;
      if (pulse !== m_pulse) begin
        failures++;
        $display("FAIL glitch_pulse edge=%0d got=%b want=%b", e, pulse, m_pulse);
      end
      checks++;
      if (level !== m_level || (e >= 7 && level !== 1'b1)) begin
        failures++;
        $display("FAIL glitch_level edge=%0d got=%b want=%b", e, level, m_level);
      end
    end
  endtask

  task automatic test_wrap;
    start_test(1'b0);
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 16; c++) begin
        tick(c < 8, 1'b1);
        checks++;
        if (pulse !== m_pulse || level !== m_level) begin
          failures++;
          $display("FAIL wrap_cycle n=%0d c=%0d got=%b%b want=%b%b", n, c, pulse, level, m_pulse, m_level);
        end
        if (pulse === 1'b1) begin
          checks++;
          if (exp_q.size() == 0 || cnt4 !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL wrap_count n=%0d got=%0d want=%0d", n, cnt4, m_cnt);
          end
        end
      end
    end
    checks++;
    if (dut_pulses != 16 || cnt4 !== 4'd0) begin
      failures++;
      $display("FAIL wrap_total pulses=%0d cnt=%0d want pulses=16 cnt=0", dut_pulses, cnt4);
    end
  endtask

  task automatic test_reset_mid_hold;
    start_test(1'b0);
    for (int e = 1; e <= 30; e++) begin
      tick(1'b1, e != 12);
      checks++;
      if (pulse !== m_pulse || pulse !== (e == 6 || e == 18)) begin
        failures++;
        $display("FAIL mid_reset_pulse edge=%0d got=%b want=%b", e, pulse, m_pulse);
      end
      checks++;
      if (level !== m_level || level !== ((e >= 6 && e < 12) || e >= 18)) begin
        failures++;
        $display("FAIL mid_reset_level edge=%0d got=%b want=%b", e, level, m_level);
      end
    end
  endtask

  task automatic test_random;
    logic b = 1'b0;
    logic prev = 1'b0;
    logic bouncy = 1'b0;
    start_test(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) bouncy = ~bouncy;
      if (bouncy) b = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 19) == 0) b = ~b;
      if ($urandom_range(0, 149) == 0) repeat_en = ~repeat_en;
      prev = pulse;
      tick(b, $urandom_range(0, 499) != 0);
      checks++;
      if (pulse !== m_pulse || level !== m_level) begin
        failures++;
        $display("FAIL random i=%0d got=%b%b want=%b%b", i, pulse, level, m_pulse, m_level);
      end
      checks++;
      if (prev === 1'b1 && pulse === 1'b1) begin
        failures++;
        $display("FAIL random_double_pulse i=%0d got=11 want=not 11", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
